// File: rtl/branch_predict_unit_if.sv
// Fetch lookup, Execute resolution and perf-counter signals between the core and the branch predictor.
interface branch_predict_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  PCF;
    logic             PredictTakenF;
    logic [XLEN-1:0]  PredictTargetF;
    logic             BranchE;
    logic [2:0]       TypeBranchE;
    logic             ZeroE;
    logic             ALUResultE;
    logic [XLEN-1:0]  PCE;
    logic [XLEN-1:0]  PCTargetE;
    logic             PredictedTakenE;
    logic [XLEN-1:0]  PredictedTargetE;
    logic             NeedBranchE;
    logic             MispredictE;
    logic [XLEN-1:0]  RedirectPCE;
    logic [CNT_W-1:0] BranchCount;
    logic [CNT_W-1:0] MispredictCount;

    modport master (
        output PCF, BranchE, TypeBranchE, ZeroE, ALUResultE, PCE, PCTargetE,
               PredictedTakenE, PredictedTargetE,
        input  PredictTakenF, PredictTargetF, NeedBranchE, MispredictE, RedirectPCE,
               BranchCount, MispredictCount
    );

    modport slave (
        input  PCF, BranchE, TypeBranchE, ZeroE, ALUResultE, PCE, PCTargetE,
               PredictedTakenE, PredictedTargetE,
        output PredictTakenF, PredictTargetF, NeedBranchE, MispredictE, RedirectPCE,
               BranchCount, MispredictCount
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters, Execute-stage branch resolution and
// saturating branch/mispredict counters for the RV32I pipeline.
module branch_predict_unit #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_predict_unit_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [ENTRIES-1:0]      valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q    [ENTRIES];
    logic [TAG_W-1:0]        tag_d    [ENTRIES];
    logic [XLEN-1:0]         target_q [ENTRIES];
    logic [XLEN-1:0]         target_d [ENTRIES];
    logic [ENTRIES-1:0][1:0] ctr_q, ctr_d;
    logic [CNT_W-1:0]        branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]        mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] f_idx, e_idx;
    logic [TAG_W-1:0] f_tag, e_tag;
    logic             f_hit, e_hit, taken;
    logic [1:0]       unused_pcf_lsbs;

    assign f_idx           = bp.PCF[IDX_W+1:2];
    assign f_tag           = bp.PCF[XLEN-1:IDX_W+2];
    assign unused_pcf_lsbs = bp.PCF[1:0];
    assign f_hit           = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign bp.PredictTakenF  = f_hit & ctr_q[f_idx][1];
    assign bp.PredictTargetF = bp.PredictTakenF ? target_q[f_idx] : '0;

    assign e_idx = bp.PCE[IDX_W+1:2];
    assign e_tag = bp.PCE[XLEN-1:IDX_W+2];
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

    // Reserved funct3 codes 010/011 resolve to not-taken rather than X.
    always_comb begin
        taken = 1'b0;
        case (bp.TypeBranchE)
            3'b000:         taken = bp.ZeroE;
            3'b001:         taken = ~bp.ZeroE;
            3'b100, 3'b110: taken = bp.ALUResultE;
            3'b101, 3'b111: taken = ~bp.ALUResultE;
            default:        taken = 1'b0;
        endcase
    end

    assign bp.NeedBranchE = bp.BranchE & taken;
    assign bp.MispredictE = bp.BranchE &
                            ((taken != bp.PredictedTakenE) |
                             (taken & (bp.PredictedTargetE != bp.PCTargetE)));
    assign bp.RedirectPCE = taken ? bp.PCTargetE : bp.PCE + XLEN'(4);

    always_comb begin
        valid_d       = valid_q;
        tag_d         = tag_q;
        target_d      = target_q;
        ctr_d         = ctr_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (bp.BranchE) begin
            if (e_hit) begin
                if (taken) begin
                    target_d[e_idx] = bp.PCTargetE;
                    if (ctr_q[e_idx] != 2'b11) ctr_d[e_idx] = ctr_q[e_idx] + 2'd1;
                end else if (ctr_q[e_idx] != 2'b00) begin
                    ctr_d[e_idx] = ctr_q[e_idx] - 2'd1;
                end
            end else begin
                // Miss replaces the entry, starting weakly biased toward the outcome.
                valid_d[e_idx]  = 1'b1;
                tag_d[e_idx]    = e_tag;
                target_d[e_idx] = bp.PCTargetE;
                ctr_d[e_idx]    = taken ? 2'b10 : 2'b01;
            end
            if (!(&branch_cnt_q)) branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (bp.MispredictE && !(&mispred_cnt_q)) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q       <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i]    <= 2'b01;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else begin
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            target_q      <= target_d;
            ctr_q         <= ctr_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bp.BranchCount     = branch_cnt_q;
    assign bp.MispredictCount = mispred_cnt_q;
endmodule
